// File: rtl/sdram_aref_if.sv
// Refresh-stage handshake and command bus between the auto-refresh block and its arbiter/PHY side.
interface sdram_aref_if;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned ADDR_W = 13;

  logic              flag_init_end;
  logic              aref_en;
  logic              aref_req;
  logic              flag_aref_end;
  logic [CMD_W-1:0]  aref_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic              err_ref_late;

  // Refresh block side
  modport master (
    input  flag_init_end,
    input  aref_en,
    output aref_req,
    output flag_aref_end,
    output aref_cmd,
    output sdram_addr,
    output err_ref_late
  );

  // Init stage / arbiter / command-mux side
  modport slave (
    output flag_init_end,
    output aref_en,
    input  aref_req,
    input  flag_aref_end,
    input  aref_cmd,
    input  sdram_addr,
    input  err_ref_late
  );
endinterface

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh: times the refresh interval after init, requests the
// arbiter, and on grant issues PREA then AREF, pulsing flag_aref_end on the last cycle.
module sdram_aref #(
  parameter int unsigned REF_INTERVAL = 390,
  parameter int unsigned TRP          = 2,
  parameter int unsigned TRFC         = 7
) (
  input  logic         sclk,
  input  logic         s_rst,
  sdram_aref_if.master bus
);

  localparam int unsigned CNT_W     = $clog2(REF_INTERVAL);
  localparam int unsigned STEP_LAST = TRP + TRFC;
  localparam int unsigned STEP_W    = $clog2(STEP_LAST + 1);

  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_PREA  = 4'b0010;
  localparam logic [3:0]  CMD_AREF  = 4'b0001;
  localparam logic [12:0] ADDR_PALL = 13'h0400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_EXEC
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              pending_q, pending_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              end_q, end_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              tick_c;

  // Interval tick: wrap of the free-running counter once init has completed
  assign tick_c = (state_q != S_IDLE) && (ref_cnt_q == CNT_W'(REF_INTERVAL - 1));

  // State register and registered outputs, synchronous reset
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q   <= S_IDLE;
      ref_cnt_q <= '0;
      step_q    <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      end_q     <= 1'b0;
      cmd_q     <= CMD_NOP;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      req_q     <= req_d;
      end_q     <= end_d;
      cmd_q     <= cmd_d;
    end
  end

  // Next-state, interval/step counters, pending/error tracking and next output values
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = '0;
    step_d    = '0;
    pending_d = pending_q;
    err_d     = err_q;
    req_d     = 1'b0;
    end_d     = 1'b0;
    cmd_d     = CMD_NOP;

    if (state_q != S_IDLE) begin
      ref_cnt_d = tick_c ? '0 : ref_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: if (bus.flag_init_end) state_d = S_WAIT;
      S_WAIT: if (pending_q) state_d = S_REQ;
      S_REQ: begin
        if (bus.aref_en) begin
          state_d   = S_EXEC;
          pending_d = 1'b0;
        end
      end
      S_EXEC: begin
        if (step_q == STEP_W'(STEP_LAST)) state_d = S_WAIT;
        else                              step_d  = step_q + STEP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A tick overrides the clear on EXEC entry; a tick on an unserved request is late
    if (tick_c) begin
      pending_d = 1'b1;
      if (pending_q) err_d = 1'b1;
    end

    req_d = (state_d == S_REQ);
    if (state_d == S_EXEC) begin
      if (step_d == '0)                cmd_d = CMD_PREA;
      else if (step_d == STEP_W'(TRP)) cmd_d = CMD_AREF;
      end_d = (step_d == STEP_W'(STEP_LAST));
    end
  end

  assign bus.aref_req      = req_q;
  assign bus.flag_aref_end = end_q;
  assign bus.aref_cmd      = cmd_q;
  assign bus.sdram_addr    = ADDR_PALL;
  assign bus.err_ref_late  = err_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: long-interval instance checked against request/error windows
// and a command scoreboard; short-interval instance checked against a vector table.
module tb_sdram_aref;

  localparam int LAST_CYC = 1600;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PREA = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  typedef struct {
    int         lo;
    int         hi;
    logic       req;
    logic       err;
  } seg_t;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic       fin;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       req;
    logic [3:0] cmd;
    logic       fin;
    logic       err;
  } vec_t;

  logic sclk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seg_t seg_a[9];
  vec_t vb[17];
  int   bi = 0;
  ev_t  sb_q[$];

  sdram_aref_if if_a ();
  sdram_aref_if if_b ();

  sdram_aref #(.REF_INTERVAL(390), .TRP(2), .TRFC(7)) u_a (
    .sclk  (sclk),
    .s_rst (rst_a),
    .bus   (if_a.master)
  );

  sdram_aref #(.REF_INTERVAL(20), .TRP(2), .TRFC(7)) u_b (
    .sclk  (sclk),
    .s_rst (rst_b),
    .bus   (if_b.master)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_grant(input int e, input bit full);
    ev_t ev;
    ev.cyc = e + 1;  ev.cmd = PREA; ev.fin = 1'b0; sb_q.push_back(ev);
    ev.cyc = e + 3;  ev.cmd = AREF; ev.fin = 1'b0; sb_q.push_back(ev);
    if (full) begin
      ev.cyc = e + 10; ev.cmd = NOP; ev.fin = 1'b1; sb_q.push_back(ev);
    end
  endtask

  // Instance A: request/error windows, constant address and command scoreboard
  always @(negedge sclk) begin
    if (cyc >= 1 && cyc <= LAST_CYC) begin
      logic exp_req;
      logic exp_err;
      exp_req = 1'b0;
      exp_err = 1'b0;
      for (int i = 0; i < 9; i++) begin
        if (cyc >= seg_a[i].lo && cyc <= seg_a[i].hi) begin
          exp_req = seg_a[i].req;
          exp_err = seg_a[i].err;
        end
      end
      chk("a_req",  int'(if_a.aref_req), int'(exp_req));
      chk("a_err",  int'(if_a.err_ref_late), int'(exp_err));
      chk("a_addr", int'(if_a.sdram_addr), 32'h0400);
      if (if_a.aref_cmd !== NOP || if_a.flag_aref_end !== 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("a_unexpected_cmd", int'({if_a.flag_aref_end, if_a.aref_cmd}), int'({1'b0, NOP}));
        end else begin
          ev_t ev;
          ev = sb_q.pop_front();
          chk("a_evt_cycle", cyc, ev.cyc);
          chk("a_evt_cmd",   int'(if_a.aref_cmd), int'(ev.cmd));
          chk("a_evt_end",   int'(if_a.flag_aref_end), int'(ev.fin));
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        ev_t ev;
        ev = sb_q.pop_front();
        chk("a_missing_evt", int'({if_a.flag_aref_end, if_a.aref_cmd}), int'({ev.fin, ev.cmd}));
      end
    end
  end

  // Instance B: compare against the vector table at the listed cycles
  always @(negedge sclk) begin
    if (bi < 17 && vb[bi].cyc == cyc) begin
      chk("b_req", int'(if_b.aref_req),      int'(vb[bi].req));
      chk("b_cmd", int'(if_b.aref_cmd),      int'(vb[bi].cmd));
      chk("b_end", int'(if_b.flag_aref_end), int'(vb[bi].fin));
      chk("b_err", int'(if_b.err_ref_late),  int'(vb[bi].err));
      bi++;
    end
  end

  initial begin
    seg_a[0] = '{1,    396,  1'b0, 1'b0};
    seg_a[1] = '{397,  400,  1'b1, 1'b0};
    seg_a[2] = '{401,  786,  1'b0, 1'b0};
    seg_a[3] = '{787,  1175, 1'b1, 1'b0};
    seg_a[4] = '{1176, 1200, 1'b1, 1'b1};
    seg_a[5] = '{1201, 1566, 1'b0, 1'b1};
    seg_a[6] = '{1567, 1570, 1'b1, 1'b1};
    seg_a[7] = '{1571, 1573, 1'b0, 1'b1};
    seg_a[8] = '{1574, LAST_CYC, 1'b0, 1'b0};

    vb[0]  = '{2,  1'b0, NOP,  1'b0, 1'b0};
    vb[1]  = '{26, 1'b0, NOP,  1'b0, 1'b0};
    vb[2]  = '{27, 1'b1, NOP,  1'b0, 1'b0};
    vb[3]  = '{45, 1'b1, NOP,  1'b0, 1'b0};
    vb[4]  = '{46, 1'b0, PREA, 1'b0, 1'b1};
    vb[5]  = '{47, 1'b0, NOP,  1'b0, 1'b1};
    vb[6]  = '{48, 1'b0, AREF, 1'b0, 1'b1};
    vb[7]  = '{54, 1'b0, NOP,  1'b0, 1'b1};
    vb[8]  = '{55, 1'b0, NOP,  1'b1, 1'b1};
    vb[9]  = '{56, 1'b0, NOP,  1'b0, 1'b1};
    vb[10] = '{57, 1'b1, NOP,  1'b0, 1'b1};
    vb[11] = '{60, 1'b1, NOP,  1'b0, 1'b1};
    vb[12] = '{61, 1'b0, PREA, 1'b0, 1'b1};
    vb[13] = '{63, 1'b0, AREF, 1'b0, 1'b1};
    vb[14] = '{70, 1'b0, NOP,  1'b1, 1'b1};
    vb[15] = '{71, 1'b0, NOP,  1'b0, 1'b1};
    vb[16] = '{72, 1'b1, NOP,  1'b0, 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.flag_init_end = 1'b0;
    if_a.aref_en       = 1'b0;
    if_b.flag_init_end = 1'b0;
    if_b.aref_en       = 1'b0;

    for (int k = 1; k <= LAST_CYC; k++) begin
      @(posedge sclk);
      #1;
      rst_a = (k < 3) || (k == 1573);
      rst_b = (k < 3);
      if_a.flag_init_end = (k >= 5 && k < 10);
      if_b.flag_init_end = (k >= 5);
      if_a.aref_en = (k == 100) || (k == 400) || (k == 1200) || (k == 1570);
      if_b.aref_en = (k == 45) || (k == 60);
      if (k == 400 || k == 1200) push_grant(k, 1'b1);
      if (k == 1570)             push_grant(k, 1'b0);
    end

    @(posedge sclk);
    @(negedge sclk);
    #1;
    chk("a_sb_left", sb_q.size(), 0);
    chk("b_vec_done", bi, 17);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
